// File: rtl/hello_world_checker.sv
// rtl/hello_world_checker.sv - 8N1 UART receiver that pulses match on each "hello world\n".
module hello_world_checker #(
  parameter int CLOCK_RATE     = 100_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int CLOCKS_PER_BIT = CLOCK_RATE / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       busy,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_error,
  output logic       match
);

  localparam int CW = $clog2(CLOCKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [3:0]    MSG_LAST  = 4'd11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [3:0]    idx;
  logic          half_tick, bit_tick;

  function automatic logic [7:0] msg_byte(input logic [3:0] i);
    case (i)
      4'd0:    msg_byte = 8'h68;
      4'd1:    msg_byte = 8'h65;
      4'd2:    msg_byte = 8'h6c;
      4'd3:    msg_byte = 8'h6c;
      4'd4:    msg_byte = 8'h6f;
      4'd5:    msg_byte = 8'h20;
      4'd6:    msg_byte = 8'h77;
      4'd7:    msg_byte = 8'h6f;
      4'd8:    msg_byte = 8'h72;
      4'd9:    msg_byte = 8'h6c;
      4'd10:   msg_byte = 8'h64;
      default: msg_byte = 8'h0a;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign half_tick = (cnt == HALF_LAST);
  assign bit_tick  = (cnt == BIT_LAST);
  assign busy      = (state == START) || (state == DATA) || (state == STOP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rxs) state_nxt = START;
      START:     if (half_tick) state_nxt = rxs ? IDLE : DATA;
      DATA:      if (bit_tick && bit_cnt == 3'd7) state_nxt = STOP;
      STOP:      if (bit_tick) state_nxt = rxs ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rxs) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Bit timing and deserialisation; counters restart at every sample point so none can wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      rx_byte     <= 8'h00;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        START: cnt <= half_tick ? '0 : cnt + 1'b1;
        DATA: begin
          if (bit_tick) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[7:1]};
            if (bit_cnt != 3'd7) bit_cnt <= bit_cnt + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            cnt <= '0;
            if (rxs) begin
              rx_byte    <= shreg;
              byte_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt     <= '0;
          bit_cnt <= 3'd0;
        end
      endcase
    end
  end

  // 'h' appears only at the head of the message, so a mismatch restarts at 0 or 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx   <= 4'd0;
      match <= 1'b0;
    end else begin
      match <= 1'b0;
      if (frame_error) begin
        idx <= 4'd0;
      end else if (byte_valid) begin
        if (rx_byte == msg_byte(idx)) begin
          if (idx == MSG_LAST) begin
            match <= 1'b1;
            idx   <= 4'd0;
          end else begin
            idx <= idx + 4'd1;
          end
        end else begin
          idx <= (rx_byte == 8'h68) ? 4'd1 : 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hello_world_checker.sv
// tb/tb_hello_world_checker.sv - directed and randomized checks of hello_world_checker.
module tb_hello_world_checker;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       busy;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_error;
  logic       match;

  int vectors     = 0;
  int miscompares = 0;

  int rx_q[$];
  int exp_q[$];
  int exp_stream[$];
  int match_cnt   = 0;
  int fe_cnt      = 0;
  int busy_cycles = 0;
  logic bv_prev   = 1'b0;

  int msg_ref[12] = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20,
                      8'h77, 8'h6f, 8'h72, 8'h6c, 8'h64, 8'h0a};

  always #5 clk = ~clk;

  hello_world_checker #(
    .CLOCK_RATE(1_600_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .busy       (busy),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_error(frame_error),
    .match      (match)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (byte_valid) rx_q.push_back(int'(rx_byte));
      if (frame_error) fe_cnt++;
      if (busy) busy_cycles++;
      if (match) begin
        match_cnt++;
        chk("match_latency", {23'd0, bv_prev, rx_byte}, {23'd0, 1'b1, 8'h0a});
      end
    end
    bv_prev = byte_valid;
  end

  task automatic clear_phase();
    rx_q.delete();
    exp_q.delete();
    exp_stream.delete();
    match_cnt   = 0;
    fe_cnt      = 0;
    busy_cycles = 0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; leaves rx at the stop level for back-to-back frames.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit record);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    if (record) begin
      if (stop_bit) begin
        exp_q.push_back(int'(b));
        exp_stream.push_back(int'(b));
      end else begin
        exp_stream.push_back(-1);
      end
    end
  endtask

  task automatic send_str(input string s, input int n, input bit record);
    for (int i = 0; i < n; i++) send_byte(s[i], 1'b1, record);
  endtask

  // Reference: count complete occurrences of the message in the recorded byte stream.
  task automatic check_phase(input string tag);
    int exp_m = 0;
    int exp_fe = 0;
    int n;
    bit ok;
    foreach (exp_stream[i]) if (exp_stream[i] < 0) exp_fe++;
    for (int i = 11; i < exp_stream.size(); i++) begin
      ok = 1'b1;
      for (int k = 0; k < 12; k++) if (exp_stream[i - 11 + k] != msg_ref[k]) ok = 1'b0;
      if (ok) exp_m++;
    end
    chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, rx_q[i], exp_q[i]);
    chk({tag, "_matches"}, match_cnt, exp_m);
    chk({tag, "_frame_errors"}, fe_cnt, exp_fe);
    clear_phase();
  endtask

  initial begin
    string hello = "hello world\n";
    int r;

    repeat (4) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rx_byte", rx_byte, 0);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_match", match, 0);
    rst = 1'b1;
    idle(2000);
    check_phase("idle");

    send_byte(8'h55, 1'b1, 1'b1);
    idle(40);
    chk("single_busy_len", (busy_cycles >= 148 && busy_cycles <= 156), 1);
    chk("single_rx_byte", rx_byte, 8'h55);
    check_phase("single");

    send_str(hello, 12, 1'b1);
    idle(40);
    check_phase("msg");

    send_str("hehello world\n", 14, 1'b1);
    idle(40);
    check_phase("hehello");
    send_str("hello worle\n", 12, 1'b1);
    idle(40);
    check_phase("worle");

    send_byte(8'h41, 1'b0, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    idle(CPB);
    send_str(hello, 12, 1'b1);
    idle(40);
    check_phase("frame_err");

    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    chk("glitch_busy_seen", (busy_cycles > 0), 1);
    chk("glitch_busy_now", busy, 0);
    check_phase("glitch");

    fork
      send_str(hello, 12, 1'b0);
      begin
        repeat (5 * 10 * CPB + 5 * CPB) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rx_byte", rx_byte, 0);
        chk("midrst_byte_valid", byte_valid, 0);
        chk("midrst_match", match, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
      end
    join
    idle(30 * CPB);
    chk("midrst_no_match", match_cnt, 0);
    clear_phase();
    send_str(hello, 12, 1'b1);
    idle(40);
    check_phase("after_rst");

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: send_str(hello, 12, 1'b1);
        1: send_str(hello, $urandom_range(1, 11), 1'b1);
        2: send_byte(8'h68, 1'b1, 1'b1);
        3: begin
          send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b1);
          idle(CPB);
        end
        default: send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b1);
      endcase
      idle($urandom_range(0, 20));
    end
    idle(40);
    check_phase("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
